pattern_detect_fsm: RTL and testbench
=====================================

PATTERN_DETECT_FSM -- requirements
Module: pattern_detect_fsm

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT, default 4'b1011: match pattern; MSB is the oldest bit.
REQ-003 Parameter LOCK_PAT, default 4'b1111: lockout pattern; SHALL differ from PAT.
REQ-004 Parameter OVERLAP, default 1: 1 = overlapping matches allowed; 0 = history flushed after each match.
REQ-005 Parameter CNT_W, default 8: match counter width, minimum 1.
REQ-006 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous reset, active low.
REQ-008 Port x, input, 1: serial data bit.
REQ-009 Port in_vld, input, 1: x is sampled only when in_vld=1.
REQ-010 Port clr, input, 1: synchronous clear.
REQ-011 Port z, output, 1: Mealy match pulse, combinational from state, x, in_vld and clr.
REQ-012 Port locked, output, 1: registered; high while in LOCKED.
REQ-013 Port match_cnt, output, CNT_W: saturating count of matches.

Function
REQ-014 The FSM SHALL have states FILL, RUN and LOCKED.
- FILL: fewer than PAT_W-1 valid bits held since the last flush.
- RUN: PAT_W-1 history bits held.
REQ-015 Window definition: window = {hist[PAT_W-2:0], x}.
REQ-016 On each edge with in_vld=1 and clr=0 in FILL or RUN, x SHALL shift into hist.
- The fill count SHALL increment, saturating at PAT_W-1.
- The FSM SHALL move FILL->RUN when fill reaches PAT_W-1.
REQ-017 Match condition: z=1 iff in_vld=1 and clr=0 and state=RUN and window==PAT; otherwise z=0, with no latency.
REQ-018 OVERLAP=0: on a match edge, fill count and hist SHALL clear to 0 and the FSM SHALL go to FILL.
REQ-019 OVERLAP=1: on a match edge, the FSM SHALL stay in RUN, so matches sharing bits are detected.
REQ-020 Lockout entry: in RUN with in_vld=1, clr=0 and window==LOCK_PAT, the next state SHALL be LOCKED.
REQ-021 LOCKED SHALL persist regardless of x and in_vld; only clr or reset exit it.
- z=0 in LOCKED.
- hist and match_cnt SHALL be frozen in LOCKED.
REQ-022 in_vld=0: no state, history or count change; z=0.
REQ-023 clr=1: next state FILL, hist=0, fill=0, match_cnt=0.
- clr SHALL take priority over in_vld; the coincident bit is discarded and z=0.
REQ-024 Each match edge SHALL increment match_cnt by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-025 Illegal state encodings SHALL recover to FILL on the next edge, with hist and fill cleared.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force: state FILL, hist=0, fill=0, locked=0, match_cnt=0.
- z=0 follows combinationally.
REQ-027 Deasserting rst_n mid-stream SHALL discard all prior bits; a full PAT_W new valid bits are needed before any match.

Configuration
REQ-028 Macro PATDET_MATCH_COUNT_EN SHALL control the match counter.
- Defined: the counter is implemented per REQ-024.
- Undefined: no counter flops; match_cnt is tied to 0; all other behaviour is unchanged.

Verification
REQ-029 Defaults, OVERLAP=1, valid bits 1,0,1,1,0,1,1 -> z=1 on bits 4 and 7 only; match_cnt=2.
REQ-030 Same stream with OVERLAP=0 -> z=1 on bit 4 only; match_cnt=1; state FILL after bit 4.
REQ-031 Bits 1,1,1,1 then 1,0,1,1 -> locked=1 from the edge after bit 4; z stays 0; match_cnt stays 0.
- clr pulse then 1,0,1,1 -> locked=0 and z=1 on the 4th bit.
REQ-032 Stream 1,0,1,1 with in_vld=0 gaps between bits, x toggling during gaps -> z=1 exactly once, on the 4th valid bit.
REQ-033 CNT_W=2, OVERLAP=1, bits 1,0,1,1,0,1,1,0,1,1,0,1,1 (four matches) -> match_cnt=3, held.
- Same run with the macro undefined -> match_cnt=0 throughout.
REQ-034 rst_n pulse after bits 1,0,1, then 1 -> z=0; then 0,1,1 -> z=1 on the 4th post-reset bit.
- clr=1 coincident with a completing bit -> z=0 and match_cnt=0.

Source files
------------

// File: rtl/pattern_detect_fsm.sv
// Serial pattern detector: Mealy match pulse, sticky lockout state and an optional
// saturating match counter (built only when PATDET_MATCH_COUNT_EN is defined).
module pattern_detect_fsm #(
    parameter int unsigned      PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT      = PAT_W'(4'b1011),
    parameter logic [PAT_W-1:0] LOCK_PAT = PAT_W'(4'b1111),
    parameter bit               OVERLAP  = 1'b1,
    parameter int unsigned      CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             in_vld,
    input  logic             clr,
    output logic             z,
    output logic             locked,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_RUN    = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                locked_q, locked_d;
    logic [PAT_W-1:0]    window;
    logic                hit;

    assign window = {hist_q, x};

    // Next-state, history and fill update; hit is the same-cycle match strobe.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        hit     = 1'b0;
        if (clr) begin
            state_d = ST_FILL;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_vld) begin
                        hist_d = window[HIST_W-1:0];
                        fill_d = fill_q + FILL_W'(1);
                        if ((fill_q + FILL_W'(1)) == FILL_W'(HIST_W)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (in_vld) begin
                        if (window == PAT) begin
                            hit = 1'b1;
                            if (OVERLAP) begin
                                hist_d = window[HIST_W-1:0];
                            end else begin
                                hist_d  = '0;
                                fill_d  = '0;
                                state_d = ST_FILL;
                            end
                        end else if (window == LOCK_PAT) begin
                            state_d = ST_LOCKED;
                        end else begin
                            hist_d = window[HIST_W-1:0];
                        end
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d = ST_FILL;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FILL;
            hist_q   <= '0;
            fill_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            locked_q <= locked_d;
        end
    end

    assign z      = hit;
    assign locked = locked_q;

`ifdef PATDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; hit is already suppressed by clr.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_detect_fsm.sv
// Bench for pattern_detect_fsm: three configurations (default, OVERLAP=0, CNT_W=2)
// driven by one stream and checked against a bit-history reference model.
module tb_pattern_detect_fsm;

    logic       clk;
    logic       rst_n;
    logic       x;
    logic       in_vld;
    logic       clr;
    logic       z_w   [3];
    logic       lk_w  [3];
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model state per instance: history value, bits held, lock flag, count
    int unsigned hv   [3];
    int unsigned hl   [3];
    bit          lk   [3];
    int unsigned mcnt [3];

    localparam int unsigned PAT_V  = 11;
    localparam int unsigned LOCK_V = 15;

    pattern_detect_fsm u0 (
        .clk(clk), .rst_n(rst_n), .x(x), .in_vld(in_vld), .clr(clr),
        .z(z_w[0]), .locked(lk_w[0]), .match_cnt(cnt0)
    );
    pattern_detect_fsm #(.OVERLAP(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .x(x), .in_vld(in_vld), .clr(clr),
        .z(z_w[1]), .locked(lk_w[1]), .match_cnt(cnt1)
    );
    pattern_detect_fsm #(.CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .x(x), .in_vld(in_vld), .clr(clr),
        .z(z_w[2]), .locked(lk_w[2]), .match_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned get_cnt(input int k);
        if (k == 0) return 32'(cnt0);
        if (k == 1) return 32'(cnt1);
        return 32'(cnt2);
    endfunction

    function automatic int unsigned exp_cnt(input int k);
`ifdef PATDET_MATCH_COUNT_EN
        return mcnt[k];
`else
        return (k >= 0) ? 0 : 1;
`endif
    endfunction

    function automatic bit model_z(input int k, input bit xb, input bit vb, input bit cb);
        int unsigned win;
        win = ((hv[k] << 1) | 32'(xb)) & 15;
        return vb && !cb && !lk[k] && (hl[k] == 3) && (win == PAT_V);
    endfunction

    task automatic model_edge(input int k, input bit xb, input bit vb, input bit cb);
        int unsigned win;
        int unsigned cmax;
        cmax = (k == 2) ? 3 : 255;
        win  = ((hv[k] << 1) | 32'(xb)) & 15;
        if (cb) begin
            hv[k] = 0; hl[k] = 0; lk[k] = 0; mcnt[k] = 0;
        end else if (vb && !lk[k]) begin
            if (hl[k] < 3) begin
                hv[k] = win & 7;
                hl[k] = hl[k] + 1;
            end else if (win == PAT_V) begin
                if (mcnt[k] < cmax) mcnt[k] = mcnt[k] + 1;
                if (k == 1) begin
                    hv[k] = 0; hl[k] = 0;
                end else begin
                    hv[k] = win & 7;
                end
            end else if (win == LOCK_V) begin
                lk[k] = 1'b1;
            end else begin
                hv[k] = win & 7;
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            hv[k] = 0; hl[k] = 0; lk[k] = 0; mcnt[k] = 0;
        end
    endtask

    // One clock: drive at negedge, check z before the edge, registered outputs after.
    task automatic step(input bit xb, input bit vb, input bit cb);
        @(negedge clk);
        x = xb; in_vld = vb; clr = cb;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("z[%0d]", k), 32'(z_w[k]), 32'(model_z(k, xb, vb, cb)));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k, xb, vb, cb);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("locked[%0d]", k), 32'(lk_w[k]), 32'(lk[k]));
            check_eq($sformatf("cnt[%0d]", k), get_cnt(k), exp_cnt(k));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; x = 1'b1; in_vld = 1'b1; clr = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst_z[%0d]", k), 32'(z_w[k]), 0);
            check_eq($sformatf("rst_locked[%0d]", k), 32'(lk_w[k]), 0);
            check_eq($sformatf("rst_cnt[%0d]", k), get_cnt(k), 0);
        end
        #2;
        rst_n = 1'b1; in_vld = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0);
    endtask

    int unsigned en;

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; x = 1'b0; in_vld = 1'b0; clr = 1'b0;
        model_reset();
`ifdef PATDET_MATCH_COUNT_EN
        en = 1;
`else
        en = 0;
`endif
        do_reset();

        // Overlapping vs flushing on 1011011
        send_bits(16'b1011011, 7);
        check_eq("ovl_cnt", get_cnt(0), 2 * en);
        check_eq("novl_cnt", get_cnt(1), 1 * en);

        // Lockout then clear
        step(1'b0, 1'b0, 1'b1);
        send_bits(16'b11111011, 8);
        check_eq("lock_hold", 32'(lk_w[0]), 1);
        check_eq("lock_cnt", get_cnt(0), 0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("lock_exit", 32'(lk_w[0]), 0);
        send_bits(16'b1011, 4);

        // in_vld gaps with x toggling
        step(1'b0, 1'b0, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] p;
            p = 4'b1011;
            step(p[i], 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end

        // Counter saturation on the narrow instance
        step(1'b0, 1'b0, 1'b1);
        send_bits(16'b1011011011011, 13);
        check_eq("sat_cnt", get_cnt(2), 3 * en);
        step(1'b1, 1'b0, 1'b0);
        check_eq("sat_hold", get_cnt(2), 3 * en);

        // Reset mid-stream discards history
        step(1'b0, 1'b0, 1'b1);
        send_bits(16'b101, 3);
        do_reset();
        send_bits(16'b1011, 4);

        // clr coincident with a completing bit
        step(1'b0, 1'b0, 1'b1);
        send_bits(16'b101, 3);
        step(1'b1, 1'b1, 1'b1);
        check_eq("clr_cnt", get_cnt(0), 0);

        // Randomized stream
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom), ($urandom_range(3) != 0), ($urandom_range(23) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
